// File: rtl/pb_event_pkg.sv
// pb_event_pkg: shared types and helpers for the push-button gesture classifier.
// The state enum lives here so that the classifier and anything that observes
// it share one encoding.
package pb_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_HELD
    } pb_state_e;

    // Width of a counter that can reach the largest of the three intervals.
    function automatic int pb_timer_width(input int long_cycles,
                                          input int dclick_cycles,
                                          input int repeat_cycles);
        int m;
        m = long_cycles;
        if (dclick_cycles > m) m = dclick_cycles;
        if (repeat_cycles > m) m = repeat_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pb_event_timer.sv
// pb_event_timer: saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping, so a long-idle gesture can never
// alias back onto a terminal count.
module pb_event_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // Count up while enabled; clear wins over enable; stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pb_event_classifier.sv
// pb_event_classifier: turns debounced press/release pulses into one-cycle
// gesture events (short press, long press, double click).
// Optional feature macro: PB_AUTOREPEAT_EN -- when defined, a held long press
// emits repeat_pulse every REPEAT_CYCLES; when undefined repeat_pulse is 0.
module pb_event_classifier
    import pb_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic PB_pressed_pulse,
    input  logic PB_released_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic busy
);

    localparam int TW = pb_timer_width(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES);

    // Terminal counts are one less than the interval: the timer reads 0 in
    // the first cycle of a state, so the event lands exactly on the interval.
    localparam logic [TW-1:0] LONG_TERM   = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] DCLICK_TERM = TW'(DCLICK_CYCLES - 1);

    pb_state_e       state;
    pb_state_e       state_nxt;
    logic [TW-1:0]   timer;
    logic            timer_clr;
    logic            press;
    logic            release_;
    logic            short_nxt;
    logic            long_nxt;
    logic            dbl_nxt;

    assign press    = PB_pressed_pulse;
    assign release_ = PB_released_pulse;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; where two inputs race, the state's own priority
    // (release in held states, press in the double-click window) wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press) state_nxt = HELD;
            end
            HELD: begin
                if (release_)                state_nxt = WAIT_SECOND;
                else if (timer == LONG_TERM) state_nxt = LONG_HELD;
            end
            LONG_HELD: begin
                if (release_) state_nxt = IDLE;
            end
            WAIT_SECOND: begin
                if (press)                     state_nxt = SECOND_HELD;
                else if (timer == DCLICK_TERM) state_nxt = IDLE;
            end
            SECOND_HELD: begin
                if (release_) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Event decode: the value each registered output takes next cycle.
    always_comb begin
        long_nxt  = (state == HELD) && !release_ && (timer == LONG_TERM);
        dbl_nxt   = (state == WAIT_SECOND) && press;
        short_nxt = (state == WAIT_SECOND) && !press && (timer == DCLICK_TERM);
    end

`ifdef PB_AUTOREPEAT_EN
    localparam logic [TW-1:0] REPEAT_TERM = TW'(REPEAT_CYCLES - 1);

    logic rep_nxt;

    // Repeat fires on the terminal count in LONG_HELD unless the release
    // arrives in the same cycle.
    always_comb begin
        rep_nxt = (state == LONG_HELD) && !release_ && (timer == REPEAT_TERM);
    end

    // A repeat restarts the period, just as a state change restarts a gesture.
    assign timer_clr = (state_nxt != state) || rep_nxt;

    // Registered repeat output.
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= rep_nxt;
        end
    end
`else
    assign timer_clr    = (state_nxt != state);
    assign repeat_pulse = 1'b0;
`endif

    // Registered gesture outputs; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_click <= dbl_nxt;
        end
    end

    assign busy = (state != IDLE);

    pb_event_timer #(
        .W(TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clr),
        .enable (1'b1),
        .count  (timer)
    );

endmodule
